// File: rtl/csr_pkg.sv
// Shared CSR bus definitions: addresses, cause codes, write types, request kinds and
// the sequencer state encoding, plus the operand-legality helpers.
package csr_pkg;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMvendorid = 12'hF11;

  localparam int unsigned CauseIllegal = 2;
  localparam int unsigned CauseBreak   = 3;
  localparam int unsigned CauseEcallM  = 11;

  localparam logic [1:0] WtRw = 2'b01;
  localparam logic [1:0] WtRs = 2'b10;
  localparam logic [1:0] WtRc = 2'b11;

  typedef enum logic [1:0] {
    KindCsr    = 2'd0,
    KindEcall  = 2'd1,
    KindEbreak = 2'd2,
    KindMret   = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StTrapEpc,
    StTrapVec,
    StRetEpc,
    StRet,
    StDone
  } seq_state_e;

  function automatic logic need_write(logic [1:0] wt, logic [4:0] src);
    return (wt == WtRw) || (src != 5'd0);
  endfunction

  function automatic logic need_read(logic [1:0] wt, logic rd_nz);
    return !((wt == WtRw) && !rd_nz);
  endfunction

  // Addresses with [11:10]==11 are read-only; writing one is an illegal instruction.
  function automatic logic illegal_csr(logic [1:0] wt, logic nw, logic [11:0] sel);
    return (wt == 2'b00) || (nw && (sel[11:10] == 2'b11));
  endfunction

endpackage

// File: rtl/csr_sequencer.sv
// Multi-cycle initiator for the CSR bus: runs CSR read/modify/write ops, ECALL, EBREAK
// and MRET against the CSR file and reports rd write-back and PC redirect to the core.
module csr_sequencer
  import csr_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CAUSE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         kind,
  input  logic [2:0]         funct3,
  input  logic [11:0]        csr_sel,
  input  logic [4:0]         src_idx,
  input  logic [XLEN-1:0]    rs1_val,
  input  logic               rd_nz,
  input  logic [XLEN-1:0]    pc,
  output logic               busy,
  output logic               done,
  output logic               rd_we,
  output logic [XLEN-1:0]    rd_value,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [11:0]        csr_addr,
  inout  wire  [XLEN-1:0]    csr_bus,
  output logic               csr_read,
  output logic               csr_write,
  output logic [1:0]         csr_write_type,
  output logic               csr_trap,
  output logic               csr_ret,
  output logic [CAUSE_W-1:0] csr_trap_cause,
  input  logic               csr_invalid
);

  seq_state_e         state_q, state_d;
  kind_e              kind_q;
  logic [1:0]         wt_q;
  logic               imm_q;
  logic [11:0]        sel_q;
  logic [4:0]         src_q;
  logic [XLEN-1:0]    rs1_q;
  logic               rd_nz_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    old_q;
  logic [XLEN-1:0]    target_q;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               trapped_q;

  logic               accept;
  logic               nw_in, nw_q;
  logic [XLEN-1:0]    operand;
  logic               bus_oe;
  logic [XLEN-1:0]    bus_out;

  assign accept  = (state_q == StIdle) && start;
  assign nw_in   = need_write(funct3[1:0], src_idx);
  assign nw_q    = need_write(wt_q, src_q);
  assign operand = imm_q ? XLEN'(src_q) : rs1_q;

  // Only WRITE and TRAP_EPC drive the bus; both are disjoint from every csr_read state.
  assign csr_bus = bus_oe ? bus_out : {XLEN{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      kind_q    <= KindCsr;
      wt_q      <= 2'b00;
      imm_q     <= 1'b0;
      sel_q     <= 12'h000;
      src_q     <= 5'd0;
      rs1_q     <= '0;
      rd_nz_q   <= 1'b0;
      pc_q      <= '0;
      old_q     <= '0;
      target_q  <= '0;
      cause_q   <= '0;
      trapped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (accept) begin
        kind_q    <= kind_e'(kind);
        wt_q      <= funct3[1:0];
        imm_q     <= funct3[2];
        sel_q     <= csr_sel;
        src_q     <= src_idx;
        rs1_q     <= rs1_val;
        rd_nz_q   <= rd_nz;
        pc_q      <= pc;
        old_q     <= '0;
        trapped_q <= 1'b0;
      end
      if (state_q == StRead) old_q <= csr_bus;
      if ((state_q == StTrapVec) || (state_q == StRetEpc)) target_q <= csr_bus;
      if (state_d == StTrapEpc) trapped_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    busy           = (state_q != StIdle);
    done           = 1'b0;
    rd_we          = 1'b0;
    rd_value       = '0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    csr_addr       = 12'h000;
    csr_read       = 1'b0;
    csr_write      = 1'b0;
    csr_write_type = 2'b00;
    csr_trap       = 1'b0;
    csr_ret        = 1'b0;
    csr_trap_cause = '0;
    bus_oe         = 1'b0;
    bus_out        = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (kind_e'(kind))
            KindCsr: begin
              if (illegal_csr(funct3[1:0], nw_in, csr_sel)) begin
                state_d = StTrapEpc;
                cause_d = CAUSE_W'(CauseIllegal);
              end else if (need_read(funct3[1:0], rd_nz)) begin
                state_d = StRead;
              end else begin
                state_d = StWrite;
              end
            end
            KindEcall: begin
              state_d = StTrapEpc;
              cause_d = CAUSE_W'(CauseEcallM);
            end
            KindEbreak: begin
              state_d = StTrapEpc;
              cause_d = CAUSE_W'(CauseBreak);
            end
            default: state_d = StRetEpc;
          endcase
        end
      end
      StRead: begin
        csr_read = 1'b1;
        csr_addr = sel_q;
        if (csr_invalid) begin
          state_d = StTrapEpc;
          cause_d = CAUSE_W'(CauseIllegal);
        end else begin
          state_d = nw_q ? StWrite : StDone;
        end
      end
      StWrite: begin
        csr_write      = 1'b1;
        csr_addr       = sel_q;
        csr_write_type = wt_q;
        bus_oe         = 1'b1;
        bus_out        = operand;
        if (csr_invalid) begin
          state_d = StTrapEpc;
          cause_d = CAUSE_W'(CauseIllegal);
        end else begin
          state_d = StDone;
        end
      end
      StTrapEpc: begin
        csr_trap       = 1'b1;
        csr_trap_cause = cause_q;
        bus_oe         = 1'b1;
        bus_out        = pc_q;
        state_d        = StTrapVec;
      end
      StTrapVec: begin
        csr_read = 1'b1;
        csr_addr = CsrMtvec;
        state_d  = StDone;
      end
      StRetEpc: begin
        csr_read = 1'b1;
        csr_addr = CsrMepc;
        state_d  = StRet;
      end
      StRet: begin
        csr_ret = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done        = 1'b1;
        rd_we       = rd_nz_q && (kind_q == KindCsr) && !trapped_q;
        rd_value    = old_q;
        redirect    = trapped_q || (kind_q == KindMret);
        redirect_pc = redirect ? target_q : '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_csr_sequencer.sv
// Directed bench: csr_sequencer against a small behavioural CSR file on the shared bus.
module tb_csr_sequencer;

  localparam logic [31:0] Probe = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  kind = 2'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [11:0] csr_sel = 12'h000;
  logic [4:0]  src_idx = 5'd0;
  logic [31:0] rs1_val = '0;
  logic        rd_nz = 1'b0;
  logic [31:0] pc = '0;
  logic        busy, done, rd_we, redirect;
  logic [31:0] rd_value, redirect_pc;
  logic [11:0] csr_addr;
  wire  [31:0] csr_bus;
  logic        csr_read, csr_write, csr_trap, csr_ret, csr_invalid;
  logic [1:0]  csr_write_type;
  logic [4:0]  csr_trap_cause;
  logic        probe = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  csr_sequencer #(.XLEN(32), .CAUSE_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .kind(kind), .funct3(funct3), .csr_sel(csr_sel),
    .src_idx(src_idx), .rs1_val(rs1_val), .rd_nz(rd_nz), .pc(pc), .busy(busy), .done(done),
    .rd_we(rd_we), .rd_value(rd_value), .redirect(redirect), .redirect_pc(redirect_pc),
    .csr_addr(csr_addr), .csr_bus(csr_bus), .csr_read(csr_read), .csr_write(csr_write),
    .csr_write_type(csr_write_type), .csr_trap(csr_trap), .csr_ret(csr_ret),
    .csr_trap_cause(csr_trap_cause), .csr_invalid(csr_invalid)
  );

  // Behavioural CSR file; not reset by rst so aborted ops can be shown side-effect free.
  logic [31:0] mstatus  = 32'h0000_1800;
  logic [31:0] mtvec    = 32'h0000_0004;
  logic [31:0] mepc     = '0;
  logic [31:0] mcause   = '0;
  logic [31:0] mscratch = '0;
  logic [31:0] rdata, wval;
  logic        hit;

  always_comb begin
    hit   = 1'b1;
    rdata = '0;
    case (csr_addr)
      12'h300: rdata = mstatus;
      12'h305: rdata = mtvec;
      12'h340: rdata = mscratch;
      12'h341: rdata = mepc;
      12'h342: rdata = mcause;
      12'hF11: rdata = '0;
      default: hit = 1'b0;
    endcase
    case (csr_write_type)
      2'b10:   wval = rdata | csr_bus;
      2'b11:   wval = rdata & ~csr_bus;
      default: wval = csr_bus;
    endcase
  end

  assign csr_invalid = (csr_read || csr_write) && !hit;
  assign csr_bus = csr_read ? rdata : (probe ? Probe : 32'bz);

  always @(posedge clk) begin
    if (csr_write && hit) begin
      case (csr_addr)
        12'h300: mstatus  <= wval;
        12'h305: mtvec    <= wval;
        12'h340: mscratch <= wval;
        12'h341: mepc     <= wval;
        12'h342: mcause   <= wval;
        default: ;
      endcase
    end
    if (csr_trap) begin
      mepc       <= csr_bus;
      mcause     <= {27'b0, csr_trap_cause};
      mstatus[7] <= mstatus[3];
      mstatus[3] <= 1'b0;
    end
    if (csr_ret) begin
      mstatus[3] <= mstatus[7];
      mstatus[7] <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus ownership and strobe exclusivity, every cycle.
  always @(negedge clk) begin
    check_eq("strobe_onehot", 32'($countones({csr_read, csr_write, csr_trap, csr_ret}) <= 1), 1);
    check_eq("bus_excl", 32'(csr_read && (csr_write || csr_trap)), 0);
  end

  int          lat;
  logic        o_we, o_redir, o_wrote;
  logic [31:0] o_val, o_rpc;

  // Issues one request; with poke, raises a conflicting start while the op is busy.
  task automatic run_op(input logic [1:0] k, input logic [2:0] f3, input logic [11:0] sel,
                        input logic [4:0] src, input logic [31:0] rs1, input logic rdnz,
                        input logic [31:0] pcv, input bit poke);
    @(negedge clk);
    kind = k; funct3 = f3; csr_sel = sel; src_idx = src; rs1_val = rs1; rd_nz = rdnz; pc = pcv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; o_we = 0; o_val = '0; o_redir = 0; o_rpc = '0; o_wrote = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (csr_write) o_wrote = 1'b1;
      if (poke && i == 1) begin
        start = 1'b1; kind = 2'd1; pc = 32'hBAD0; rs1_val = '0; src_idx = 5'd7;
      end
      if (poke && i == 2) start = 1'b0;
      if (done) begin
        lat = i; o_we = rd_we; o_val = rd_value; o_redir = redirect; o_rpc = redirect_pc;
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_strobes", {csr_read, csr_write, csr_trap, csr_ret}, 0);
    check_eq("rst_addr", csr_addr, 0);
    probe = 1'b1;
    #1 check_eq("rst_bus_z", csr_bus, Probe);
    probe = 1'b0;

    // CSRRW mscratch, with a start raised mid-op that must be ignored
    run_op(2'd0, 3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 1'b1, 32'h40, 1'b1);
    check_eq("rw_lat", lat, 3);
    check_eq("rw_we", o_we, 1);
    check_eq("rw_val", o_val, 0);
    check_eq("rw_redir", o_redir, 0);
    check_eq("rw_wrote", o_wrote, 1);
    check_eq("rw_mscratch", mscratch, 32'hDEADBEEF);
    check_eq("busy_start_ignored", mcause, 0);

    run_op(2'd0, 3'b010, 12'h340, 5'd0, 32'h0, 1'b1, 32'h44, 1'b0);
    check_eq("reread_lat", lat, 2);
    check_eq("reread_val", o_val, 32'hDEADBEEF);
    check_eq("reread_wrote", o_wrote, 0);

    run_op(2'd0, 3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'h48, 1'b0);
    check_eq("ms_lat", lat, 2);
    check_eq("ms_we", o_we, 1);
    check_eq("ms_val", o_val, 32'h1800);
    check_eq("ms_wrote", o_wrote, 0);

    // unimplemented CSR: invalid in READ
    run_op(2'd0, 3'b001, 12'h7C0, 5'd1, 32'h55, 1'b1, 32'h200, 1'b0);
    check_eq("inv_lat", lat, 4);
    check_eq("inv_we", o_we, 0);
    check_eq("inv_redir", o_redir, 1);
    check_eq("inv_rpc", o_rpc, 4);
    check_eq("inv_wrote", o_wrote, 0);
    check_eq("inv_mepc", mepc, 32'h200);
    check_eq("inv_mcause", mcause, 2);

    // CSRRSI mstatus, zimm=8 sets MIE
    run_op(2'd0, 3'b110, 12'h300, 5'd8, 32'h0, 1'b0, 32'h60, 1'b0);
    check_eq("rsi_lat", lat, 3);
    check_eq("rsi_we", o_we, 0);
    check_eq("rsi_mstatus", mstatus, 32'h1808);

    run_op(2'd1, 3'b000, 12'h000, 5'd0, 32'h0, 1'b0, 32'h100, 1'b0);
    check_eq("ecall_lat", lat, 3);
    check_eq("ecall_redir", o_redir, 1);
    check_eq("ecall_rpc", o_rpc, 4);
    check_eq("ecall_we", o_we, 0);
    check_eq("ecall_mcause", mcause, 11);
    check_eq("ecall_mepc", mepc, 32'h100);
    check_eq("ecall_mstatus", mstatus, 32'h1880);

    run_op(2'd3, 3'b000, 12'h000, 5'd0, 32'h0, 1'b0, 32'h300, 1'b0);
    check_eq("mret_lat", lat, 3);
    check_eq("mret_redir", o_redir, 1);
    check_eq("mret_rpc", o_rpc, 32'h100);
    check_eq("mret_mstatus", mstatus, 32'h1888);

    // write to read-only mvendorid: illegal at decode
    run_op(2'd0, 3'b001, 12'hF11, 5'd1, 32'h1234, 1'b1, 32'h400, 1'b0);
    check_eq("ro_lat", lat, 3);
    check_eq("ro_wrote", o_wrote, 0);
    check_eq("ro_redir", o_redir, 1);
    check_eq("ro_rpc", o_rpc, 4);
    check_eq("ro_we", o_we, 0);
    check_eq("ro_mcause", mcause, 2);
    check_eq("ro_mepc", mepc, 32'h400);

    // read-only access to mvendorid is legal
    run_op(2'd0, 3'b010, 12'hF11, 5'd0, 32'h0, 1'b1, 32'h404, 1'b0);
    check_eq("rdonly_lat", lat, 2);
    check_eq("rdonly_we", o_we, 1);
    check_eq("rdonly_redir", o_redir, 0);

    run_op(2'd2, 3'b000, 12'h000, 5'd0, 32'h0, 1'b0, 32'h500, 1'b0);
    check_eq("ebreak_lat", lat, 3);
    check_eq("ebreak_mcause", mcause, 3);
    check_eq("ebreak_mepc", mepc, 32'h500);

    // rd=x0 CSRRW skips the read
    run_op(2'd0, 3'b001, 12'h340, 5'd3, 32'h0BADF00D, 1'b0, 32'h600, 1'b0);
    check_eq("skip_lat", lat, 2);
    check_eq("skip_we", o_we, 0);
    check_eq("skip_val", o_val, 0);
    check_eq("skip_mscratch", mscratch, 32'h0BADF00D);

    // write_type 00 is illegal
    run_op(2'd0, 3'b000, 12'h340, 5'd0, 32'h0, 1'b1, 32'h700, 1'b0);
    check_eq("wt0_lat", lat, 3);
    check_eq("wt0_mcause", mcause, 2);
    check_eq("wt0_redir", o_redir, 1);

    // async reset while in READ aborts the op
    @(negedge clk);
    kind = 2'd0; funct3 = 3'b001; csr_sel = 12'h340; src_idx = 5'd1;
    rs1_val = 32'h1111_1111; rd_nz = 1'b1; pc = 32'h800;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_eq("abort_in_read", csr_read, 1);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_strobes", {csr_read, csr_write, csr_trap, csr_ret, done}, 0);
    probe = 1'b1;
    #1 check_eq("abort_bus_z", csr_bus, Probe);
    probe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort_mscratch", mscratch, 32'h0BADF00D);
    check_eq("abort_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
